// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg
//   Types and constants shared by the cache-line to AXI bridge:
//   - read and write engine state enums
//   - line geometry and the fixed AXI burst encoding
//   - the line_t container
package cache_axi_pkg;

  localparam int LINE_WORDS = 4;
  localparam int ADDR_W     = 32;

  // Index of the final beat in a line burst.
  localparam logic [1:0] LAST_BEAT  = 2'(LINE_WORDS - 1);

  localparam logic [3:0] BURST_LEN  = 4'd3;    // AXI len = beats - 1
  localparam logic [2:0] SIZE_WORD  = 3'd2;    // 4 bytes per beat
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] STRB_ALL   = 4'hF;

  typedef logic [127:0] line_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_DATA,
    R_DONE
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_AW,
    W_DATA,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge
//   Responder for the cache memory-side line port. Each accepted line read
//   becomes one 4-beat INCR burst on AR/R. Each accepted line write becomes
//   one 4-beat INCR burst on AW/W/B. The two engines run concurrently.
//   A read is held off while a write to the same line is outstanding, so a
//   read always observes an earlier write-back of its line.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   rd_req/rd_addr/rd_rdy           line read request handshake
//   ret_valid/ret_data              returned line (one-cycle pulse, data held)
//   wr_req/wr_addr/wr_data/wr_rdy   line write-back request handshake
//   ar*/r*                          AXI read address and read data channels
//   aw*/w*/b*                       AXI write address, data and response channels
module cache_axi_bridge
  import cache_axi_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  // cache read side
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rdy,
  output logic              ret_valid,
  output line_t             ret_data,
  // cache write side
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  line_t             wr_data,
  output logic              wr_rdy,
  // AXI read address
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  // AXI read data
  input  logic [31:0]       rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // AXI write address
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  // AXI write data
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // AXI write response
  input  logic              bvalid,
  output logic              bready
);

  rd_state_t   rstate, rstate_nxt;
  wr_state_t   wstate, wstate_nxt;

  logic [27:0] rline, wline;      // latched line addresses (addr[31:4])
  line_t       rbuf, wbuf;        // line being assembled / being written
  line_t       rbuf_merged;       // rbuf with the current beat inserted
  line_t       ret_line;
  logic [1:0]  rcnt, wcnt;

  logic        rd_fire, wr_fire, line_hit;
  logic        r_beat, r_end, w_beat;
  logic        unused_offset;

  // Byte offsets within a line are meaningless for whole-line transfers.
  assign unused_offset = ^{rd_addr[3:0], wr_addr[3:0]};

  // ---------------------------------------------------------------------------
  // Request acceptance and read-after-write ordering
  // ---------------------------------------------------------------------------
  assign wr_rdy  = (wstate == W_IDLE) && !reset;
  assign wr_fire = wr_req && wr_rdy;

  // A read must not overtake a write-back of the same line, whether the write
  // is already in flight or is being accepted in this very cycle.
  assign line_hit = ((wstate != W_IDLE) && (wline == rd_addr[31:4])) ||
                    (wr_fire && (wr_addr[31:4] == rd_addr[31:4]));

  assign rd_rdy  = (rstate == R_IDLE) && !line_hit && !reset;
  assign rd_fire = rd_req && rd_rdy;

  // rready is high for the whole of R_DATA, so a beat is simply rvalid there.
  // A missing rlast on the fourth beat still closes the burst.
  assign r_beat = (rstate == R_DATA) && rvalid;
  assign r_end  = r_beat && (rlast || (rcnt == LAST_BEAT));
  assign w_beat = (wstate == W_DATA) && wready;

  // ---------------------------------------------------------------------------
  // Constant burst fields and datapath outputs
  // ---------------------------------------------------------------------------
  assign araddr   = {rline, 4'b0000};
  assign arlen    = BURST_LEN;
  assign arsize   = SIZE_WORD;
  assign arburst  = BURST_INCR;
  assign awaddr   = {wline, 4'b0000};
  assign awlen    = BURST_LEN;
  assign awsize   = SIZE_WORD;
  assign awburst  = BURST_INCR;
  assign wstrb    = STRB_ALL;
  assign wdata    = wbuf[32*int'(wcnt) +: 32];
  assign ret_data = ret_line;

  always_comb begin
    rbuf_merged = rbuf;
    rbuf_merged[32*int'(rcnt) +: 32] = rdata;
  end

  // ---------------------------------------------------------------------------
  // Read engine next-state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default before the case
  // so no path leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    rstate_nxt = rstate;
    arvalid    = 1'b0;
    rready     = 1'b0;
    ret_valid  = 1'b0;
    case (rstate)
      R_IDLE: if (rd_fire) rstate_nxt = R_AR;
      R_AR: begin
        arvalid = 1'b1;
        if (arready) rstate_nxt = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (r_end) rstate_nxt = R_DONE;
      end
      R_DONE: begin
        ret_valid  = 1'b1;
        rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write engine next-state / outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    wstate_nxt = wstate;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    bready     = 1'b0;
    case (wstate)
      W_IDLE: if (wr_fire) wstate_nxt = W_AW;
      W_AW: begin
        awvalid = 1'b1;
        if (awready) wstate_nxt = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        wlast  = (wcnt == LAST_BEAT);
        if (wready && (wcnt == LAST_BEAT)) wstate_nxt = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state: states, beat counters, returned line
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rstate   <= R_IDLE;
      wstate   <= W_IDLE;
      rcnt     <= 2'd0;
      wcnt     <= 2'd0;
      ret_line <= '0;
    end else begin
      rstate <= rstate_nxt;
      wstate <= wstate_nxt;
      // Counters restart on accept so an early rlast cannot skew the next burst.
      if (rd_fire)     rcnt <= 2'd0;
      else if (r_beat) rcnt <= rcnt + 2'd1;
      if (wr_fire)     wcnt <= 2'd0;
      else if (w_beat) wcnt <= wcnt + 2'd1;
      if (r_end)       ret_line <= rbuf_merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers and latched addresses
  // ---------------------------------------------------------------------------
  // NOTE: these registers carry no reset; they are only observed after an
  // accept has loaded them, so resetting them would add logic for no effect.
  always_ff @(posedge clk) begin
    if (rd_fire) rline <= rd_addr[31:4];
    if (r_beat)  rbuf  <= rbuf_merged;
    if (wr_fire) begin
      wline <= wr_addr[31:4];
      wbuf  <= wr_data;
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge
//   Directed bench for cache_axi_bridge. The bench plays the AXI slave with
//   hand-chosen stall patterns and compares every observed value against
//   hand-computed constants. Inputs change 1 time unit after the rising edge;
//   outputs are sampled on the falling edge.
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rd_req = 1'b0;
  logic [31:0]  rd_addr = '0;
  logic         rd_rdy;
  logic         ret_valid;
  logic [127:0] ret_data;
  logic         wr_req = 1'b0;
  logic [31:0]  wr_addr = '0;
  logic [127:0] wr_data = '0;
  logic         wr_rdy;
  logic [31:0]  araddr;
  logic [3:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [31:0]  rdata = '0;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [31:0]  awaddr;
  logic [3:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready = 1'b0;
  logic         bvalid = 1'b0;
  logic         bready;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [127:0] L_A = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] L_B = 128'h0BADF00D_12345678_CAFEBABE_DEADBEEF;
  localparam logic [127:0] L_C = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L_D = 128'h80000001_00FF00FF_A5A5A5A5_7E7E7E7E;
  localparam logic [127:0] W_A = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] W_B = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] W_C = 128'hFEEDFACE_C0FFEE00_13579BDF_2468ACE0;

  always #5 clk = ~clk;

  cache_axi_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_data  (ret_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bvalid    (bvalid),
    .bready    (bready)
  );

  // Advance to the next cycle's drive point.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a read request and wait (bounded) for it to be accepted.
  task automatic rd_request(input logic [31:0] addr, input string name);
    bit ok = 0;
    rd_req  = 1'b1;
    rd_addr = addr;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (rd_rdy === 1'b1) ok = 1;
      next_cycle();
    end
    rd_req = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s rd_accept: rd_rdy never 1 (got timeout, expected accept)", name);
    end
  endtask

  // Present a write request and wait (bounded) for it to be accepted.
  task automatic wr_request(input logic [31:0] addr, input logic [127:0] data,
                            input string name);
    bit ok = 0;
    wr_req  = 1'b1;
    wr_addr = addr;
    wr_data = data;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (wr_rdy === 1'b1) ok = 1;
      next_cycle();
    end
    wr_req = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s wr_accept: wr_rdy never 1 (got timeout, expected accept)", name);
    end
  endtask

  // Serve an accepted read: AR accepted at once, beats with 'gap' idle cycles
  // before each, rlast on beat 4. Starts in the cycle after acceptance.
  task automatic rd_service(input logic [31:0] exp_addr, input logic [127:0] line,
                            input int gap, input string name);
    bit ok = 0;
    int lat = 0;
    arready = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (arvalid === 1'b1) begin
        ok  = 1;
        lat = n;
        tests_run++;
        if (araddr !== exp_addr || arlen !== 4'd3 || arsize !== 3'd2 || arburst !== 2'b01) begin
          tests_failed++;
          $display("FAIL %s ar_fields: got addr=%h len=%0d size=%0d burst=%0d expected addr=%h len=3 size=2 burst=1",
                   name, araddr, arlen, arsize, arburst, exp_addr);
        end
      end
      next_cycle();
    end
    arready = 1'b0;
    tests_run++;
    if (!ok || lat != 0) begin
      tests_failed++;
      $display("FAIL %s ar_latency: got ok=%0d cycles=%0d expected arvalid in first cycle", name, ok, lat);
    end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        rvalid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rready !== 1'b1 || ret_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s gap_rready: got rready=%b ret_valid=%b expected 1/0", name, rready, ret_valid);
        end
        next_cycle();
      end
      rvalid = 1'b1;
      rdata  = line[32*k +: 32];
      rlast  = (k == 3);
      @(negedge clk);
      tests_run++;
      if (rready !== 1'b1 || ret_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s beat%0d_rready: got rready=%b ret_valid=%b expected 1/0", name, k, rready, ret_valid);
      end
      next_cycle();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ret_valid !== 1'b1 || ret_data !== line) begin
      tests_failed++;
      $display("FAIL %s ret: got valid=%b data=%h expected valid=1 data=%h", name, ret_valid, ret_data, line);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (ret_valid !== 1'b0 || ret_data !== line || rready !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s ret_hold: got valid=%b rready=%b data=%h expected 0/0 data=%h",
               name, ret_valid, rready, ret_data, line);
    end
    next_cycle();
  endtask

  // Serve an accepted write. pat supplies awready (bit c) and wready
  // (bit (c+5)%16) per cycle. With chk_rd set, a same-line read is being held
  // and rd_rdy must stay 0 until the B handshake completes.
  task automatic wr_service(input logic [31:0] exp_addr, input logic [127:0] line,
                            input logic [15:0] pat, input bit chk_rd, input string name);
    bit ok = 0;
    int k = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      awready = pat[c % 16];
      @(negedge clk);
      tests_run++;
      if (awvalid !== 1'b1 || wvalid !== 1'b0 || (chk_rd && rd_rdy !== 1'b0)) begin
        tests_failed++;
        $display("FAIL %s aw_phase: got awvalid=%b wvalid=%b rd_rdy=%b expected 1/0/%s",
                 name, awvalid, wvalid, rd_rdy, chk_rd ? "0" : "x");
      end
      if (awready) begin
        ok = 1;
        tests_run++;
        if (awaddr !== exp_addr || awlen !== 4'd3 || awsize !== 3'd2 || awburst !== 2'b01) begin
          tests_failed++;
          $display("FAIL %s aw_fields: got addr=%h len=%0d size=%0d burst=%0d expected addr=%h len=3 size=2 burst=1",
                   name, awaddr, awlen, awsize, awburst, exp_addr);
        end
      end
      next_cycle();
    end
    awready = 1'b0;
    for (int c = 0; c < 60 && k < 4; c++) begin
      wready = pat[(c + 5) % 16];
      @(negedge clk);
      tests_run++;
      if (wvalid !== 1'b1 || wstrb !== 4'hF || (chk_rd && rd_rdy !== 1'b0)) begin
        tests_failed++;
        $display("FAIL %s w_phase: got wvalid=%b wstrb=%h rd_rdy=%b expected 1/f/%s",
                 name, wvalid, wstrb, rd_rdy, chk_rd ? "0" : "x");
      end
      if (wready) begin
        tests_run++;
        if (wdata !== line[32*k +: 32] || wlast !== (k == 3)) begin
          tests_failed++;
          $display("FAIL %s w_beat%0d: got wdata=%h wlast=%b expected wdata=%h wlast=%b",
                   name, k, wdata, wlast, line[32*k +: 32], (k == 3));
        end
        k++;
      end
      next_cycle();
    end
    wready = 1'b0;
    tests_run++;
    if (k != 4) begin
      tests_failed++;
      $display("FAIL %s w_beats: got %0d beats expected 4", name, k);
    end
    bvalid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bready !== 1'b1 || wvalid !== 1'b0 || wr_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s b_wait: got bready=%b wvalid=%b wr_rdy=%b expected 1/0/0", name, bready, wvalid, wr_rdy);
    end
    next_cycle();
    bvalid = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bready !== 1'b1 || wr_rdy !== 1'b0 || (chk_rd && rd_rdy !== 1'b0)) begin
      tests_failed++;
      $display("FAIL %s b_hs: got bready=%b wr_rdy=%b rd_rdy=%b expected 1/0/%s",
               name, bready, wr_rdy, rd_rdy, chk_rd ? "0" : "x");
    end
    next_cycle();
    bvalid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (wr_rdy !== 1'b1 || bready !== 1'b0 || (chk_rd && rd_rdy !== 1'b1)) begin
      tests_failed++;
      $display("FAIL %s after_b: got wr_rdy=%b bready=%b rd_rdy=%b expected 1/0/%s",
               name, wr_rdy, bready, rd_rdy, chk_rd ? "1" : "x");
    end
    next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    tests_run++;
    if ({arvalid, rready, ret_valid, awvalid, wvalid, wlast, bready, rd_rdy, wr_rdy} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 000000000",
               {arvalid, rready, ret_valid, awvalid, wvalid, wlast, bready, rd_rdy, wr_rdy});
    end
    tests_run++;
    if (ret_data !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset_ret_data: got %h expected 0", ret_data);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_rdy: got rd_rdy=%b wr_rdy=%b expected 1/1", rd_rdy, wr_rdy);
    end
    next_cycle();
  endtask

  task automatic test_read_zero_wait();
    rd_request(32'h1FC0_0014, "rd_zero");
    rd_service(32'h1FC0_0010, L_A, 0, "rd_zero");
  endtask

  task automatic test_rvalid_gaps();
    for (int g = 0; g < 4; g++) begin
      rd_request(32'h1FC0_0014, "rd_gap");
      rd_service(32'h1FC0_0010, L_A, g, "rd_gap");
    end
  endtask

  task automatic test_write_stalls();
    wr_request(32'h8000_0020, W_A, "wr_stall");
    wr_service(32'h8000_0020, W_A, 16'b1011_0010_1101_0100, 1'b0, "wr_stall");
  endtask

  task automatic test_same_line();
    wr_req  = 1'b1;
    wr_addr = 32'h8000_0020;
    wr_data = W_C;
    rd_req  = 1'b1;
    rd_addr = 32'h8000_0024;
    @(negedge clk);
    tests_run++;
    if (wr_rdy !== 1'b1 || rd_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_line_accept: got wr_rdy=%b rd_rdy=%b expected 1/0", wr_rdy, rd_rdy);
    end
    next_cycle();
    wr_req = 1'b0;
    // rd_req stays high; it is accepted in the cycle after the B handshake.
    wr_service(32'h8000_0020, W_C, 16'b0110_1100_1001_0101, 1'b1, "wr_same");
    rd_req = 1'b0;
    rd_service(32'h8000_0020, L_B, 0, "rd_after_wr");
  endtask

  task automatic test_diff_lines();
    wr_req  = 1'b1;
    wr_addr = 32'h8000_0040;
    wr_data = W_B;
    rd_req  = 1'b1;
    rd_addr = 32'h8000_0080;
    @(negedge clk);
    tests_run++;
    if (wr_rdy !== 1'b1 || rd_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL diff_line_accept: got wr_rdy=%b rd_rdy=%b expected 1/1", wr_rdy, rd_rdy);
    end
    next_cycle();
    wr_req = 1'b0;
    rd_req = 1'b0;
    fork
      rd_service(32'h8000_0080, L_C, 1, "rd_diff");
      wr_service(32'h8000_0040, W_B, 16'hFFFF, 1'b0, "wr_diff");
    join
  endtask

  task automatic test_reset_mid();
    // Write engine into W_DATA after one beat.
    wr_request(32'h8000_0100, W_A, "wr_mid");
    awready = 1'b1;
    @(negedge clk);
    next_cycle();
    awready = 1'b0;
    wready  = 1'b1;
    @(negedge clk);
    next_cycle();
    wready = 1'b0;
    // Read engine into R_DATA after one beat.
    rd_request(32'h8000_0200, "rd_mid");
    arready = 1'b1;
    @(negedge clk);
    next_cycle();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h0000_0055;
    @(negedge clk);
    next_cycle();
    rvalid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rready !== 1'b1 || wvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_busy: got rready=%b wvalid=%b expected 1/1", rready, wvalid);
    end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (rd_rdy !== 1'b0 || wr_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_rdy: got rd_rdy=%b wr_rdy=%b expected 0/0", rd_rdy, wr_rdy);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if ({arvalid, rready, ret_valid, awvalid, wvalid, wlast, bready, rd_rdy, wr_rdy} !== 9'b0 ||
        ret_data !== 128'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_idle: got ctrl=%b ret_data=%h expected 000000000 and 0",
               {arvalid, rready, ret_valid, awvalid, wvalid, wlast, bready, rd_rdy, wr_rdy}, ret_data);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_release_rdy: got rd_rdy=%b wr_rdy=%b expected 1/1", rd_rdy, wr_rdy);
    end
    next_cycle();
    rd_request(32'h1FC0_0014, "rd_post_reset");
    rd_service(32'h1FC0_0010, L_D, 2, "rd_post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read_zero_wait();
    test_rvalid_gaps();
    test_write_stalls();
    test_same_line();
    test_diff_lines();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
